// File: rtl/uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_drain
// Purpose  : Read-side consumer of the TX FIFO. Pops one byte with a single
//            cycle active-low strobe, waits out the FIFO read latency, then
//            serializes start, 7/8 data bits (LSB first), optional parity and
//            stop bit(s) onto tx, paced by the shared oversampling baud tick.
// Ports    : clk, reset (async, active high), baud_tick (OVERSAMPLE per bit),
//            fifo_empty, fifo_data[7:0], fifo_rdb (active-low read strobe),
//            bit8, parity_en, odd_n_even, stop2 (only with
//            UART_TX_TWO_STOP_EN), tx (idle = 1), tx_busy.
// Options  : `define UART_TX_TWO_STOP_EN adds the stop2 port (2 stop bits).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_drain #(
  parameter int DATA_LAT   = 2,
  parameter int OVERSAMPLE = 16,
  parameter int OS_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rdb,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
`ifdef UART_TX_TWO_STOP_EN
  input  logic       stop2,
`endif
  output logic       tx,
  output logic       tx_busy
);

  localparam int LAT_W = $clog2(DATA_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_tx, w_tx_nxt;
  logic              r_rdb, w_rdb_nxt;
  logic              r_busy, w_busy_nxt;
  logic [LAT_W-1:0]  r_lat, w_lat_nxt;
  logic [OS_W-1:0]   r_os, w_os_nxt;
  logic [2:0]        r_bit, w_bit_nxt;
  logic [7:0]        r_sh, w_sh_nxt;
  logic              r_par, w_par_nxt;
  logic              r_bit8, w_bit8_nxt;
  logic              r_paren, w_paren_nxt;
  logic              r_stop2, w_stop2_nxt;
  logic              r_stopcnt, w_stopcnt_nxt;

  logic              w_stop2_in;
  logic              w_bit_end;
  logic [2:0]        w_last_bit;

`ifdef UART_TX_TWO_STOP_EN
  assign w_stop2_in = stop2;
`else
  assign w_stop2_in = 1'b0;
`endif

  // A bit period closes on the tick that would take the counter past its top.
  assign w_bit_end  = baud_tick && (r_os == OS_W'(OVERSAMPLE - 1));
  assign w_last_bit = r_bit8 ? 3'd7 : 3'd6;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_rdb     <= 1'b1;
      r_busy    <= 1'b0;
      r_lat     <= '0;
      r_os      <= '0;
      r_bit     <= '0;
      r_sh      <= '0;
      r_par     <= 1'b0;
      r_bit8    <= 1'b0;
      r_paren   <= 1'b0;
      r_stop2   <= 1'b0;
      r_stopcnt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx      <= w_tx_nxt;
      r_rdb     <= w_rdb_nxt;
      r_busy    <= w_busy_nxt;
      r_lat     <= w_lat_nxt;
      r_os      <= w_os_nxt;
      r_bit     <= w_bit_nxt;
      r_sh      <= w_sh_nxt;
      r_par     <= w_par_nxt;
      r_bit8    <= w_bit8_nxt;
      r_paren   <= w_paren_nxt;
      r_stop2   <= w_stop2_nxt;
      r_stopcnt <= w_stopcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tx_nxt      = r_tx;
    w_rdb_nxt     = 1'b1;
    w_busy_nxt    = r_busy;
    w_lat_nxt     = r_lat;
    w_os_nxt      = r_os;
    w_bit_nxt     = r_bit;
    w_sh_nxt      = r_sh;
    w_par_nxt     = r_par;
    w_bit8_nxt    = r_bit8;
    w_paren_nxt   = r_paren;
    w_stop2_nxt   = r_stop2;
    w_stopcnt_nxt = r_stopcnt;

    // Tick counter only runs while a bit is on the line.
    if ((r_state == S_START) || (r_state == S_DATA) ||
        (r_state == S_PARITY) || (r_state == S_STOP)) begin
      if (baud_tick) begin
        w_os_nxt = w_bit_end ? '0 : r_os + 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        w_os_nxt = '0;
        if (!fifo_empty) begin
          w_rdb_nxt   = 1'b0;
          w_busy_nxt  = 1'b1;
          w_lat_nxt   = '0;
          w_state_nxt = S_FETCH;
        end
      end

      // One cycle for the strobe to register in the FIFO, then DATA_LAT more
      // before read data is sampled.
      S_FETCH: begin
        if (r_lat == LAT_W'(DATA_LAT)) begin
          w_sh_nxt      = fifo_data;
          w_par_nxt     = (^{fifo_data[7] & bit8, fifo_data[6:0]}) ^ odd_n_even;
          w_bit8_nxt    = bit8;
          w_paren_nxt   = parity_en;
          w_stop2_nxt   = w_stop2_in;
          w_stopcnt_nxt = 1'b0;
          w_os_nxt      = '0;
          w_bit_nxt     = '0;
          w_tx_nxt      = 1'b0;
          w_state_nxt   = S_START;
        end else begin
          w_lat_nxt = r_lat + 1'b1;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_tx_nxt    = r_sh[0];
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end

      // r_sh[0] is always the bit currently on the line.
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit == w_last_bit) begin
            w_bit_nxt = '0;
            if (r_paren) begin
              w_tx_nxt    = r_par;
              w_state_nxt = S_PARITY;
            end else begin
              w_tx_nxt    = 1'b1;
              w_state_nxt = S_STOP;
            end
          end else begin
            w_sh_nxt  = {1'b0, r_sh[7:1]};
            w_tx_nxt  = r_sh[1];
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (w_bit_end) begin
          w_tx_nxt    = 1'b1;
          w_state_nxt = S_STOP;
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          if (r_stop2 && !r_stopcnt) begin
            w_stopcnt_nxt = 1'b1;
          end else begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign tx       = r_tx;
  assign fifo_rdb = r_rdb;
  assign tx_busy  = r_busy;

endmodule
`default_nettype wire
